// File: rtl/unsign_to_float.sv
// Unsigned fixed-point (DIN_WIDTH, DIN_POINT) to IEEE-754 single converter.
// Four-stage datapath plus output hold register; ROUND_NEAREST_EN selects RNE, else truncate.
module unsign_to_float #(
  parameter int DIN_WIDTH = 32,
  parameter int DIN_POINT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIN_WIDTH-1:0] din,
  input  logic                 din_valid,
  output logic [31:0]          dout,
  output logic                 dout_valid,
  output logic                 dout_inexact
);

  localparam int EW = DIN_WIDTH + 25;

  // S1: input register
  logic [DIN_WIDTH-1:0] din1_q;
  logic                 v1_q;

  // S2: leading-one position and zero detect
  logic [6:0]           msb2_d, msb2_q;
  logic                 nz2_d, nz2_q;
  logic [DIN_WIDTH-1:0] din2_q;
  logic                 v2_q;

  // S3: normalized mantissa with guard/sticky
  logic [6:0]    shift3;
  logic [EW-1:0] ext3;
  logic [9:0]    exp3_full;
  logic [22:0]   mant3_d, mant3_q;
  logic          guard3_d, guard3_q;
  logic          sticky3_d, sticky3_q;
  logic [7:0]    exp3_d, exp3_q;
  logic          nz3_q, v3_q;

  // S4: rounded and packed result
  logic [22:0] mant4;
  logic [7:0]  exp4;
  logic [31:0] pack4_d, pack4_q;
  logic        inexact4_d, inexact4_q;
  logic        v4_q;

  logic [31:0] dout_q;
  logic        dout_inexact_q, dout_valid_q;

  always_comb begin
    msb2_d = '0;
    for (int i = 0; i < DIN_WIDTH; i++) begin
      if (din1_q[i]) msb2_d = 7'(i);
    end
    nz2_d = |din1_q;
  end

  // Shifting one past the leading one drops the hidden bit off the top.
  always_comb begin
    shift3    = 7'(DIN_WIDTH) - msb2_q;
    ext3      = {din2_q, 25'b0} << shift3;
    mant3_d   = ext3[EW-1 -: 23];
    guard3_d  = ext3[DIN_WIDTH+1];
    sticky3_d = |ext3[DIN_WIDTH:0];
    exp3_full = 10'd127 + 10'(msb2_q) - 10'(DIN_POINT);
    exp3_d    = exp3_full[7:0];
  end

`ifdef ROUND_NEAREST_EN
  logic        round_up4;
  logic [23:0] mant_sum4;

  always_comb begin
    round_up4 = guard3_q & (sticky3_q | mant3_q[0]);
    mant_sum4 = {1'b0, mant3_q} + 24'(round_up4);
    mant4     = mant_sum4[22:0];
    exp4      = exp3_q + 8'(mant_sum4[23]);
  end
`else
  always_comb begin
    mant4 = mant3_q;
    exp4  = exp3_q;
  end
`endif

  always_comb begin
    pack4_d    = nz3_q ? {1'b0, exp4, mant4} : 32'h0000_0000;
    inexact4_d = nz3_q & (guard3_q | sticky3_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din1_q         <= '0;
      v1_q           <= 1'b0;
      din2_q         <= '0;
      msb2_q         <= '0;
      nz2_q          <= 1'b0;
      v2_q           <= 1'b0;
      mant3_q        <= '0;
      guard3_q       <= 1'b0;
      sticky3_q      <= 1'b0;
      exp3_q         <= '0;
      nz3_q          <= 1'b0;
      v3_q           <= 1'b0;
      pack4_q        <= '0;
      inexact4_q     <= 1'b0;
      v4_q           <= 1'b0;
      dout_q         <= '0;
      dout_inexact_q <= 1'b0;
      dout_valid_q   <= 1'b0;
    end else begin
      din1_q     <= din;
      v1_q       <= din_valid;
      din2_q     <= din1_q;
      msb2_q     <= msb2_d;
      nz2_q      <= nz2_d;
      v2_q       <= v1_q;
      mant3_q    <= mant3_d;
      guard3_q   <= guard3_d;
      sticky3_q  <= sticky3_d;
      exp3_q     <= exp3_d;
      nz3_q      <= nz2_q;
      v3_q       <= v2_q;
      pack4_q    <= pack4_d;
      inexact4_q <= inexact4_d;
      v4_q       <= v3_q;
      dout_valid_q <= v4_q;
      if (v4_q) begin
        dout_q         <= pack4_q;
        dout_inexact_q <= inexact4_q;
      end
    end
  end

  assign dout         = dout_q;
  assign dout_valid   = dout_valid_q;
  assign dout_inexact = dout_inexact_q;

endmodule

// File: tb/tb_unsign_to_float.sv
// Bench for unsign_to_float: real-arithmetic reference, cycle-by-cycle compare,
// directed literals, random streaming with gaps, and mid-stream async reset.
module tb_unsign_to_float;

  localparam int W  = 32;
  localparam int PT = 16;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  din;
  logic          din_valid;
  logic [31:0]   dout;
  logic          dout_valid;
  logic          dout_inexact;

  int n_checks = 0;
  int n_errors = 0;

  unsign_to_float #(.DIN_WIDTH(W), .DIN_POINT(PT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .din          (din),
    .din_valid    (din_valid),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .dout_inexact (dout_inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Value is scaled to [1,2) with real arithmetic; the fraction times 2^23 gives the mantissa.
  function automatic void model(input logic [W-1:0] d, output logic [31:0] f, output logic inx);
    real    v, m_real, rem;
    int     e;
    longint m;
    if (d == '0) begin
      f   = 32'h0;
      inx = 1'b0;
      return;
    end
    v = real'(longint'(d));
    for (int i = 0; i < PT; i++) v = v / 2.0;
    e = 0;
    while (v >= 2.0) begin v = v / 2.0; e++; end
    while (v < 1.0)  begin v = v * 2.0; e--; end
    m_real = (v - 1.0) * 8388608.0;
    m      = longint'($floor(m_real));
    rem    = m_real - $floor(m_real);
    inx    = (rem != 0.0);
`ifdef ROUND_NEAREST_EN
    if (rem > 0.5 || (rem == 0.5 && m[0])) m++;
    if (m == 64'd8388608) begin
      m = 0;
      e++;
    end
`endif
    f = {1'b0, 8'(127 + e), 23'(m)};
  endfunction

  // Expected-output delay line: entry 4 is what the DUT should present after this edge.
  logic        pv[5];
  logic [31:0] pd[5];
  logic        pi[5];
  logic [31:0] last_d;
  logic        last_i;

  initial begin
    for (int k = 0; k < 5; k++) begin pv[k] = 1'b0; pd[k] = '0; pi[k] = 1'b0; end
    last_d = '0;
    last_i = 1'b0;
  end

  always @(posedge clk) begin
    logic [31:0] f;
    logic        x;
    if (!rst_n) begin
      for (int k = 0; k < 5; k++) begin pv[k] = 1'b0; pd[k] = '0; pi[k] = 1'b0; end
      last_d = '0;
      last_i = 1'b0;
    end else begin
      for (int k = 4; k > 0; k--) begin pv[k] = pv[k-1]; pd[k] = pd[k-1]; pi[k] = pi[k-1]; end
      model(din, f, x);
      pv[0] = din_valid;
      pd[0] = f;
      pi[0] = x;
    end
    #1;
    if (pv[4]) begin
      last_d = pd[4];
      last_i = pi[4];
    end
    chk("dout_valid", 32'(dout_valid), 32'(pv[4]));
    chk("dout", dout, last_d);
    chk("dout_inexact", 32'(dout_inexact), 32'(last_i));
  end

  localparam int ND = 7;
  logic [31:0] lit_in  [ND];
  logic [31:0] lit_out [ND];
  logic        lit_inx [ND];

  initial begin
    lit_in[0] = 32'h0001_0000; lit_out[0] = 32'h3F80_0000; lit_inx[0] = 1'b0;
    lit_in[1] = 32'h0001_8000; lit_out[1] = 32'h3FC0_0000; lit_inx[1] = 1'b0;
    lit_in[2] = 32'h0000_0000; lit_out[2] = 32'h0000_0000; lit_inx[2] = 1'b0;
    lit_in[3] = 32'h0000_0001; lit_out[3] = 32'h3780_0000; lit_inx[3] = 1'b0;
    lit_in[4] = 32'h0100_0001; lit_out[4] = 32'h4380_0000; lit_inx[4] = 1'b1;
`ifdef ROUND_NEAREST_EN
    lit_in[5] = 32'h0100_0003; lit_out[5] = 32'h4380_0002; lit_inx[5] = 1'b1;
    lit_in[6] = 32'hFFFF_FFFF; lit_out[6] = 32'h4780_0000; lit_inx[6] = 1'b1;
`else
    lit_in[5] = 32'h0100_0003; lit_out[5] = 32'h4380_0001; lit_inx[5] = 1'b1;
    lit_in[6] = 32'hFFFF_FFFF; lit_out[6] = 32'h477F_FFFF; lit_inx[6] = 1'b1;
`endif
  end

  function automatic logic [31:0] rand_din();
    logic [31:0] r;
    case ($urandom_range(0, 7))
      0:       r = 32'h0;
      1:       r = (($urandom | 32'h8000_0000) & 32'hFFFF_FF00) | 32'h0000_0080;
      2:       r = $urandom | 32'h8000_0000;
      default: r = $urandom >> $urandom_range(0, 31);
    endcase
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] mf;
    logic        mx;
    int          sent;

    rst_n     = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    #2 rst_n  = 1'b0;

    for (int k = 0; k < ND; k++) begin
      model(lit_in[k], mf, mx);
      chk("model_literal", mf, lit_out[k]);
      chk("model_literal_inexact", 32'(mx), 32'(lit_inx[k]));
    end

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int k = 0; k < ND; k++) begin
      din       = lit_in[k];
      din_valid = 1'b1;
      @(negedge clk);
      din_valid = 1'b0;
      din       = $urandom;
      repeat (5) @(negedge clk);
      chk("directed_dout", dout, lit_out[k]);
      chk("directed_inexact", 32'(dout_inexact), 32'(lit_inx[k]));
    end

    sent = 0;
    while (sent < 1000) begin
      din       = rand_din();
      din_valid = ($urandom_range(0, 9) < 7);
      if (din_valid) sent++;
      @(negedge clk);
    end
    din_valid = 1'b0;
    repeat (6) @(negedge clk);

    for (int k = 0; k < 3; k++) begin
      din       = 32'h0001_0000 << k;
      din_valid = 1'b1;
      @(negedge clk);
    end
    din_valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("reset_dout_valid", 32'(dout_valid), 32'h0);
    chk("reset_dout", dout, 32'h0);
    chk("reset_inexact", 32'(dout_inexact), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    for (int k = 0; k < 5; k++) begin
      din       = rand_din();
      din_valid = 1'b1;
      @(negedge clk);
    end
    din_valid = 1'b0;
    repeat (8) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
